// File: rtl/mem_access_pkg.sv
// Shared size codes, FSM state encoding and byte-count helper for the MEM-stage access unit.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_STROBE = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory bus of the MEM-stage access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              req_store;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [1:0]        mem_size;
  logic [31:0]       mem_dout;

  modport slave (
    input  req, req_store, req_size, req_addr, req_wdata, mem_dout,
    output stall, done, err, rdata, mem_en, mem_rw, mem_addr, mem_din, mem_size
  );

  modport master (
    output req, req_store, req_size, req_addr, req_wdata, mem_dout,
    input  stall, done, err, rdata, mem_en, mem_rw, mem_addr, mem_din, mem_size
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Zero-extends raw memory read data to the access size; shared with the WB stage.
module load_formatter
  import mem_access_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [31:0] i_dout,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_rdata = 32'd0;
    case (i_size)
      SIZE_BYTE: o_rdata = {24'd0, i_dout[7:0]};
      SIZE_HALF: o_rdata = {16'd0, i_dout[15:0]};
      SIZE_WORD: o_rdata = i_dout;
      default:   o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for data_ram256x8: IDLE -> SETUP -> STROBE -> DONE, one access per 4 cycles.
// Define ALIGN_CHECK_EN to reject misaligned half/word accesses as bad requests.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.slave  bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_err;
  logic              r_store;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_din;
  logic [31:0]       r_rdata;
  logic [31:0]       w_fmt;
  logic [ADDR_W:0]   w_end;
  logic              w_bad;
  logic              w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.req;

  // One extra address bit so the end-of-range sum cannot wrap.
  always_comb begin
    w_end = {1'b0, bus.req_addr} + (ADDR_W+1)'(size_bytes(bus.req_size));
    w_bad = (bus.req_size == SIZE_ILL) || (w_end > (ADDR_W+1)'(MEM_DEPTH));
`ifdef ALIGN_CHECK_EN
    if ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
      w_bad = 1'b1;
    if ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00))
      w_bad = 1'b1;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req) w_state_next = w_bad ? S_DONE : S_SETUP;
      S_SETUP:  w_state_next = S_STROBE;
      S_STROBE: w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_store <= 1'b0;
      r_size  <= SIZE_WORD;
      r_addr  <= '0;
      r_din   <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_store <= bus.req_store;
        r_size  <= bus.req_size;
        r_addr  <= bus.req_addr;
        r_din   <= bus.req_wdata;
        r_err   <= w_bad;
        if (w_bad)
          r_rdata <= 32'd0;
      end
      if (r_state == S_STROBE)
        r_rdata <= r_store ? 32'd0 : w_fmt;
    end
  end

  load_formatter u_fmt (
    .i_size  (r_size),
    .i_dout  (bus.mem_dout),
    .o_rdata (w_fmt)
  );

  // Enable is cut by reset immediately so an aborted store never reaches the RAM.
  assign bus.mem_en   = (r_state == S_STROBE) && !reset;
  assign bus.mem_rw   = r_store;
  assign bus.mem_addr = r_addr;
  assign bus.mem_din  = r_din;
  assign bus.mem_size = r_size;
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = (r_state == S_DONE) && r_err;
  assign bus.rdata    = r_rdata;
  assign bus.stall    = bus.req && (r_state != S_DONE);

endmodule
